// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler
//   Packs three UART bytes (MSB first) into a 24-bit host command and holds it
//   until the dispatcher consumes it. A partial frame is dropped when the gap
//   between its bytes reaches TIMEOUT clocks. Single response bytes are passed
//   to the UART transmitter, one at a time.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_rdy, rx_data       UART received byte (level, held until cleared)
//   clr_rx_rdy            one-cycle clear back to the UART receiver
//   cmd, cmd_rdy          assembled command and its valid flag
//   clr_cmd_rdy           dispatcher has taken cmd
//   resp_data, send_resp  response byte and transmit request
//   tx_data, trmt         byte and one-cycle strobe to the UART transmitter
//   tx_done, resp_sent    transmitter complete / one-cycle completion pulse
//   frame_err             one-cycle pulse when a partial frame times out
module uart_cmd_assembler #(
    parameter int unsigned TIMEOUT = 65536,
    parameter int unsigned TO_W    = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        GOT1,
        GOT2,
        FULL
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    rx_state_t       rx_state_q, rx_state_d;
    tx_state_t       tx_state_q, tx_state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [23:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic            clr_rx_rdy_q, clr_rx_rdy_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            trmt_q, trmt_d;
    logic            resp_sent_q, resp_sent_d;
    logic            accept;

    // rx_rdy is still high in the cycle our clear is on its way to the UART;
    // masking with clr_rx_rdy_q stops the same byte being taken twice.
    assign accept = rx_rdy && !clr_rx_rdy_q && (rx_state_q != FULL);

    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        cmd_rdy_d    = cmd_rdy_q;
        clr_rx_rdy_d = 1'b0;
        frame_err_d  = 1'b0;

        case (rx_state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    cmd_d[23:16] = rx_data;
                    clr_rx_rdy_d = 1'b1;
                    rx_state_d   = GOT1;
                end
            end
            GOT1: begin
                // An accept on the final count wins over the timeout.
                if (accept) begin
                    cmd_d[15:8]  = rx_data;
                    clr_rx_rdy_d = 1'b1;
                    cnt_d        = '0;
                    rx_state_d   = GOT2;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                    rx_state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            GOT2: begin
                if (accept) begin
                    cmd_d[7:0]   = rx_data;
                    clr_rx_rdy_d = 1'b1;
                    cnt_d        = '0;
                    cmd_rdy_d    = 1'b1;
                    rx_state_d   = FULL;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                    rx_state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            FULL: begin
                // rx_rdy is left pending here; that is the back-pressure.
                cnt_d = '0;
                if (clr_cmd_rdy) begin
                    cmd_rdy_d  = 1'b0;
                    rx_state_d = IDLE;
                end
            end
            default: begin
                cnt_d      = '0;
                rx_state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_d  = resp_data;
                    trmt_d     = 1'b1;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                // tx_done is ignored while our own strobe is still out.
                if (tx_done && !trmt_q) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q   <= IDLE;
            cnt_q        <= '0;
            cmd_q        <= '0;
            cmd_rdy_q    <= 1'b0;
            clr_rx_rdy_q <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_state_q   <= TX_IDLE;
            tx_data_q    <= '0;
            trmt_q       <= 1'b0;
            resp_sent_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            cmd_rdy_q    <= cmd_rdy_d;
            clr_rx_rdy_q <= clr_rx_rdy_d;
            frame_err_q  <= frame_err_d;
            tx_state_q   <= tx_state_d;
            tx_data_q    <= tx_data_d;
            trmt_q       <= trmt_d;
            resp_sent_q  <= resp_sent_d;
        end
    end

    assign clr_rx_rdy = clr_rx_rdy_q;
    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign frame_err  = frame_err_q;
    assign tx_data    = tx_data_q;
    assign trmt       = trmt_q;
    assign resp_sent  = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler with a small inter-byte timeout.
// Expected commands and transmit bytes are queued when driven and compared
// by a monitor when the DUT raises cmd_rdy / trmt.
module tb_uart_cmd_assembler;

    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int clr_cnt = 0;
    int ferr_cnt = 0;
    int rs_cnt = 0;
    int trmt_cnt = 0;
    int base;
    int base2;
    logic cmd_rdy_prev = 1'b0;

    logic [23:0] exp_cmd_q[$];
    logic [7:0]  exp_tx_q[$];

    uart_cmd_assembler #(.TIMEOUT(TO), .TO_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp_data  (resp_data),
        .send_resp  (send_resp),
        .resp_sent  (resp_sent),
        .tx_data    (tx_data),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor samples on the falling edge; the main sequence acts 1 ns later.
    always @(negedge clk) begin
        if (clr_rx_rdy === 1'b1) clr_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
        if (resp_sent === 1'b1) rs_cnt++;
        if (trmt === 1'b1) begin
            trmt_cnt++;
            check("tx_expected_pending", 32'(exp_tx_q.size() != 0), 32'd1);
            if (exp_tx_q.size() != 0) check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
        end
        if (cmd_rdy === 1'b1 && cmd_rdy_prev !== 1'b1) begin
            check("cmd_expected_pending", 32'(exp_cmd_q.size() != 0), 32'd1);
            if (exp_cmd_q.size() != 0) check("cmd", {8'h0, cmd}, {8'h0, exp_cmd_q.pop_front()});
        end
        cmd_rdy_prev = cmd_rdy;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Presents a byte and holds rx_rdy until the DUT clears it.
    task automatic send_byte(input logic [7:0] b);
        logic seen;
        seen = 1'b0;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (clr_rx_rdy === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        rx_rdy = 1'b0;
        check("rx_accept_seen", {31'h0, seen}, 32'd1);
    endtask

    task automatic clear_cmd();
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("cmd_rdy_cleared", {31'h0, cmd_rdy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd"}, {8'h0, cmd}, 32'h0);
        check({tag, "_cmd_rdy"}, {31'h0, cmd_rdy}, 32'h0);
        check({tag, "_clr_rx_rdy"}, {31'h0, clr_rx_rdy}, 32'h0);
        check({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
        check({tag, "_trmt"}, {31'h0, trmt}, 32'h0);
        check({tag, "_resp_sent"}, {31'h0, resp_sent}, 32'h0);
        check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        rx_rdy = 1'b0;
        rx_data = 8'h00;
        clr_cmd_rdy = 1'b0;
        resp_data = 8'h00;
        send_resp = 1'b0;
        tx_done = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Three spaced bytes form one command.
        base = clr_cnt;
        send_byte(8'h08);
        tick(20);
        send_byte(8'h2A);
        tick(20);
        check("partial_no_cmd_rdy", {31'h0, cmd_rdy}, 32'd0);
        exp_cmd_q.push_back(24'h082AFF);
        send_byte(8'hFF);
        check("cmd_rdy_latency", {31'h0, cmd_rdy}, 32'd1);
        tick(3);
        check("clr_rx_rdy_pulses", 32'(clr_cnt - base), 32'd3);
        clear_cmd();

        // Timeout lands exactly TO clocks after the accepting edge.
        base = ferr_cnt;
        send_byte(8'h02);
        tick(TO - 1);
        check("no_early_timeout", 32'(ferr_cnt - base), 32'd0);
        tick(1);
        check("frame_err_pulse", {31'h0, frame_err}, 32'd1);
        tick(1);
        check("frame_err_one_cycle", {31'h0, frame_err}, 32'd0);
        check("frame_err_count", 32'(ferr_cnt - base), 32'd1);
        check("timeout_no_cmd_rdy", {31'h0, cmd_rdy}, 32'd0);
        send_byte(8'h03);
        send_byte(8'hFF);
        exp_cmd_q.push_back(24'h03FFAA);
        send_byte(8'hAA);
        tick(1);
        clear_cmd();

        // Accept on the final count of both gaps beats the timeout.
        base = ferr_cnt;
        send_byte(8'h10);
        tick(TO - 1);
        send_byte(8'h20);
        tick(TO - 1);
        exp_cmd_q.push_back(24'h102030);
        send_byte(8'h30);
        tick(2);
        check("boundary_accept_no_frame_err", 32'(ferr_cnt - base), 32'd0);
        clear_cmd();

        // Back-pressure while FULL, then pending byte lands in the top lane.
        send_byte(8'h05);
        send_byte(8'hFF);
        exp_cmd_q.push_back(24'h05FF02);
        send_byte(8'h02);
        base  = clr_cnt;
        base2 = ferr_cnt;
        rx_data = 8'h07;
        rx_rdy  = 1'b1;
        tick(TO + 6);
        check("full_no_clr_rx_rdy", 32'(clr_cnt - base), 32'd0);
        check("full_no_timeout", 32'(ferr_cnt - base2), 32'd0);
        check("full_cmd_rdy_held", {31'h0, cmd_rdy}, 32'd1);
        check("full_cmd_held", {8'h0, cmd}, 32'h05FF02);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("clr_edge_cmd_rdy_low", {31'h0, cmd_rdy}, 32'd0);
        check("clr_edge_no_accept", {31'h0, clr_rx_rdy}, 32'd0);
        tick(1);
        check("pending_byte_accepted", {31'h0, clr_rx_rdy}, 32'd1);
        rx_rdy = 1'b0;
        check("lane_write_top_only", {8'h0, cmd}, 32'h07FF02);
        send_byte(8'h11);
        exp_cmd_q.push_back(24'h071122);
        send_byte(8'h22);
        tick(1);
        clear_cmd();

        // Transmit path.
        base  = trmt_cnt;
        base2 = rs_cnt;
        exp_tx_q.push_back(8'hA5);
        resp_data = 8'hA5;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        check("trmt_high", {31'h0, trmt}, 32'd1);
        check("tx_data_a5", {24'h0, tx_data}, 32'hA5);
        tick(1);
        check("trmt_one_cycle", {31'h0, trmt}, 32'd0);
        resp_data = 8'h5A;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        tick(1);
        check("busy_send_dropped_data", {24'h0, tx_data}, 32'hA5);
        check("busy_send_dropped_trmt", 32'(trmt_cnt - base), 32'd1);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        check("resp_sent_high", {31'h0, resp_sent}, 32'd1);
        tick(1);
        check("resp_sent_one_cycle", {31'h0, resp_sent}, 32'd0);
        check("resp_sent_count", 32'(rs_cnt - base2), 32'd1);

        // tx_done during the strobe cycle is not taken.
        exp_tx_q.push_back(8'h3C);
        resp_data = 8'h3C;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        check("tx_done_during_trmt_ignored", {31'h0, resp_sent}, 32'd0);
        tick(2);
        check("tx_done_during_trmt_count", 32'(rs_cnt - base2), 32'd1);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        check("resp_sent_after_busy", {31'h0, resp_sent}, 32'd1);
        tick(1);

        // Reset mid-frame and mid-transmit.
        send_byte(8'h01);
        send_byte(8'h03);
        exp_tx_q.push_back(8'h77);
        resp_data = 8'h77;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick(1);
        rst_n = 1'b1;
        tick(1);
        exp_tx_q.push_back(8'h44);
        resp_data = 8'h44;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        check("tx_idle_after_reset", {31'h0, trmt}, 32'd1);
        tx_done = 1'b1;
        tick(2);
        tx_done = 1'b0;
        send_byte(8'h09);
        send_byte(8'h2A);
        exp_cmd_q.push_back(24'h092A00);
        send_byte(8'h00);
        tick(1);
        check("cmd_after_reset", {8'h0, cmd}, 32'h092A00);
        clear_cmd();

        tick(3);
        check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
        check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
